// File: rtl/prefetch_store_buffer_if.sv
// Bus bundle between the prefetcher FSM / L1 side and the store buffer.
// The master modport is the FSM+L1 view. The slave modport is the buffer view.
interface prefetch_store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // store side
  logic              wr_en_i;
  logic [ADDR_W-1:0] w_addr_i;
  logic [DATA_W-1:0] w_data_i;
  // load side
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              wait_o;
  logic              data_ready_o;
  logic [DATA_W-1:0] data_o;
  logic              hit_o;
  // drain side
  logic              drain_valid_o;
  logic [ADDR_W-1:0] drain_addr_o;
  logic [DATA_W-1:0] drain_data_o;
  logic              drain_ready_i;
  // status
  logic [CNT_W-1:0]  count_o;
  logic              full_o;
  logic              empty_o;
  logic              overflow_o;

  modport master (
    output wr_en_i, w_addr_i, w_data_i, rd_req_i, rd_addr_i, drain_ready_i,
    input  wait_o, data_ready_o, data_o, hit_o, drain_valid_o, drain_addr_o,
           drain_data_o, count_o, full_o, empty_o, overflow_o
  );

  modport slave (
    input  wr_en_i, w_addr_i, w_data_i, rd_req_i, rd_addr_i, drain_ready_i,
    output wait_o, data_ready_o, data_o, hit_o, drain_valid_o, drain_addr_o,
           drain_data_o, count_o, full_o, empty_o, overflow_o
  );
endinterface

// File: rtl/prefetch_store_buffer.sv
// Store buffer beside the prefetcher FSM.
// It is an in-order circular FIFO of {addr, data} drained to the L1.
// Loads get store-to-load forwarding and are answered after a fixed latency.
module prefetch_store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LD_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  prefetch_store_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int LAT_W = $clog2(LD_LATENCY + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_mem;
  logic [DEPTH-1:0][DATA_W-1:0] data_mem;
  logic [DEPTH-1:0]             valid_q;
  logic [PTR_W-1:0]             head, tail;
  logic [CNT_W-1:0]             count;
  logic                         overflow_q;
  logic                         full, empty, push, pop;

  logic [1:0]                   state;
  logic [LAT_W-1:0]             lat_cnt;
  logic [DATA_W-1:0]            snap_data, last_data;
  logic                         snap_hit;

  logic [DEPTH-1:0][PTR_W-1:0]  ord_idx;
  logic                         fwd_hit;
  logic [DATA_W-1:0]            fwd_data;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign pop   = ~empty & bus.drain_ready_i;
  assign push  = bus.wr_en_i & (~full | pop);

  assign bus.drain_valid_o = ~empty;
  assign bus.drain_addr_o  = addr_mem[head];
  assign bus.drain_data_o  = data_mem[head];
  assign bus.count_o       = count;
  assign bus.full_o        = full;
  assign bus.empty_o       = empty;
  assign bus.overflow_o    = overflow_q;

  // Entry indices ordered oldest (k=0) to youngest, starting at the head.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    assign ord_idx[k] = head + PTR_W'(k);
  end

  // Forwarding search: a later (younger) match overrides an earlier one.
  // A same-cycle push is the youngest of all.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[ord_idx[k]] && addr_mem[ord_idx[k]] == bus.rd_addr_i) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[ord_idx[k]];
      end
    end
    if (push && bus.w_addr_i == bus.rd_addr_i) begin
      fwd_hit  = 1'b1;
      fwd_data = bus.w_data_i;
    end
  end

  // FIFO control: pointers, per-entry valid bits, occupancy and the sticky drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // The pop is applied before the push, so a full push+pop on the same slot leaves it valid.
      if (pop) begin
        head          <= head + 1'b1;
        valid_q[head] <= 1'b0;
      end
      if (push) begin
        tail          <= tail + 1'b1;
        valid_q[tail] <= 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (bus.wr_en_i && !push) overflow_q <= 1'b1;
    end
  end

  // Entry payload is don't-care after reset, so it is not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= bus.w_addr_i;
      data_mem[tail] <= bus.w_data_i;
    end
  end

  // Load FSM: snapshot on accept, count down the latency, then pulse for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      lat_cnt   <= '0;
      snap_data <= '0;
      snap_hit  <= 1'b0;
      last_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.rd_req_i) begin
          snap_data <= fwd_data;
          snap_hit  <= fwd_hit;
          lat_cnt   <= LAT_W'(LD_LATENCY - 1);
          state     <= (LD_LATENCY == 1) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) state <= S_RESP;
        end
        S_RESP: begin
          last_data <= snap_data;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // data_o shows the snapshot in RESP and holds the last returned word otherwise.
  assign bus.wait_o       = (state != S_IDLE);
  assign bus.data_ready_o = (state == S_RESP);
  assign bus.hit_o        = (state == S_RESP) & snap_hit;
  assign bus.data_o       = (state == S_RESP) ? snap_data : last_data;
endmodule
